setup_hold_sweep_ctrl: RTL and testbench
========================================

Name: setup_hold_sweep_ctrl

Overview:
- Synthesizable sequencer for flip-flop timing characterisation, replacing hand-written delay loops in characterisation benches.
- Drives a DUT flop's clock and data from a fast reference clock and sweeps the data-to-clock offset per (clock-slope, data-slope) pair.
- Detects the pass/fail boundary with early exit, in setup or hold mode, and streams one result per pair over a valid/ready interface.

Parameters:
NB_SLOPES_CK, 3, number of clock-transition indices swept
NB_SLOPES_D, 3, number of data-transition indices swept
FRAME, 1024, ticks per trial frame (one DUT clock period)
CK_EDGE, 512, tick within frame where dut_ck rises (falls at 0)
OFFS_MAX, 500, first offset tried (ticks); must be < CK_EDGE and < FRAME-CK_EDGE
OFFS_STEP, 1, offset decrement per trial
SETTLE_CYC, 2048, idle ticks after each slope-index change
CAPT_DLY, 16, ticks after CK_EDGE at which synchronised dut_q is sampled; must be >= 3

Ports:
clk  in  1  reference clock, one tick = one offset unit
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse, starts a full sweep; ignored while busy
mode  in  1  0 = setup sweep, 1 = hold sweep; sampled on start
busy  out  1  high from start acceptance to return to IDLE
done  out  1  one-cycle pulse when the last result is accepted
dut_ck  out  1  clock to DUT
dut_d  out  1  data to DUT
dut_q  in  1  DUT output, asynchronous to clk
ck_slope_idx  out  $clog2(NB_SLOPES_CK)  clock-slope index for the analog bench
d_slope_idx  out  $clog2(NB_SLOPES_D)  data-slope index for the analog bench
res_valid  out  1  result valid
res_ready  in  1  consumer ready
res_ck_idx  out  $clog2(NB_SLOPES_CK)  pair clock index
res_d_idx  out  $clog2(NB_SLOPES_D)  pair data index
res_offset  out  OFFS_W  smallest passing offset; OFFS_W = $clog2(OFFS_MAX+1)
res_status  out  2  0 = boundary found, 1 = passed down to offset 0, 2 = never passed, 3 = clear error

Behaviour:
- Reset values: all outputs 0, state IDLE, indices 0.
- States: IDLE -> SETTLE -> TRIAL -> CLEAR -> (TRIAL | REPORT) -> (SETTLE | IDLE).
- IDLE: on start, latch mode, ck_idx = d_idx = 0, offset = OFFS_MAX, busy = 1, go to SETTLE.
- SETTLE: dut_d = 0, dut_ck toggles with normal frame timing; wait SETTLE_CYC ticks, then TRIAL at frame tick 0.
- TRIAL, setup mode: dut_d rises at tick CK_EDGE-offset and stays high through frame end.
- TRIAL, hold mode: dut_d rises at tick 0 and falls at CK_EDGE+offset.
- dut_ck: low at ticks [0, CK_EDGE), high at [CK_EDGE, FRAME).
- Pass: synchronised q == 1 at tick CK_EDGE+CAPT_DLY.
- CLEAR: one frame with dut_d = 0. Synchronised q must be 0 at CK_EDGE+CAPT_DLY; otherwise status = 3 and go to REPORT.
- After a pass: record last_pass = offset. If offset < OFFS_STEP, status = 1 and go to REPORT; else offset -= OFFS_STEP and run the next TRIAL.
- After a fail: if no pass has been seen, status = 2 and res_offset = all-ones; else status = 0 and res_offset = last_pass. Go to REPORT (early exit).
- REPORT: res_valid held with stable payload until res_valid && res_ready. Then d_idx++; on d_idx wrap, ck_idx++. Reset offset and the pass flag, go to SETTLE.
- After the final pair is accepted: done pulse, busy = 0, go to IDLE.
- Slope indices change only on REPORT exit; they are stable through SETTLE and all trials.
- Offset arithmetic is unsigned. Underflow is prevented by the OFFS_STEP compare; there is no wrap.
- Frame counter wraps FRAME-1 -> 0.
- rst mid-sweep: immediate return to reset values, dut_d/dut_ck low, no result emitted.
- start while busy: ignored.
- res_ready high with res_valid low: no effect.

Decomposition:
- Package sweep_pkg: state enum, status codes (ST_FOUND, ST_ALLPASS, ST_NEVER, ST_CLRERR), all-ones sentinel constant.
- Sub-module q_sync2: 2-flop synchroniser on dut_q, asynchronously reset to 0 by rst. Its latency is covered by the CAPT_DLY >= 3 constraint.

Test Plan:
- Behavioural DUT flop with setup requirement 37 ticks, setup mode, OFFS_MAX = 500, step 1 -> every pair reports offset 37, status 0; 9 results then done.
- Setup requirement 0, setup mode -> offset 0, status 1 for all pairs.
- DUT q stuck at 0 -> status 2, res_offset all-ones, one trial per pair.
- DUT q stuck at 1 -> status 3 after the first CLEAR frame.
- Hold mode, hold requirement 12 ticks, step 4 -> offset 12, status 0; dut_d falls exactly at CK_EDGE+offset in each trial.
- res_ready held low 100 cycles in REPORT -> payload stable, no index advance. Separately, assert rst mid-TRIAL -> all outputs 0 within the same cycle, and a new start runs a clean sweep.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared types and constants for the setup/hold sweep sequencer.
//   state_t   : sequencer states
//   status_t  : per-pair result codes carried on res_status
//   OFFS_ALL_ONES : sentinel source, sliced to the offset width where used
//   idx_w()   : index width that never collapses to zero bits
package sweep_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_TRIAL,
    S_CLEAR,
    S_REPORT
  } state_t;

  typedef enum logic [1:0] {
    ST_FOUND   = 2'd0,
    ST_ALLPASS = 2'd1,
    ST_NEVER   = 2'd2,
    ST_CLRERR  = 2'd3
  } status_t;

  localparam logic [31:0] OFFS_ALL_ONES = 32'hFFFF_FFFF;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/setup_hold_sweep_ctrl_q_sync2.sv
// Two-flop synchroniser bringing the DUT flop output into the clk domain.
//   clk : reference clock
//   rst : asynchronous active-high reset, clears both stages
//   d   : asynchronous input
//   q   : synchronised output (two clk of latency)
module q_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/setup_hold_sweep_ctrl.sv
// Setup/hold characterisation sequencer. Generates DUT clock and data from
// the reference clock, sweeps the data-to-clock offset downward for every
// (clock-slope, data-slope) pair, exits early at the pass/fail boundary and
// streams one result per pair on a valid/ready port.
//   clk, rst            : reference clock, async active-high reset
//   start, mode         : sweep launch pulse, 0 = setup / 1 = hold
//   busy, done          : sweep in progress, end-of-sweep pulse
//   dut_ck, dut_d, dut_q: DUT flop clock, data and (asynchronous) output
//   ck_slope_idx, d_slope_idx : slope selection for the analog bench
//   res_*               : result stream (indices, offset, status)
module setup_hold_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned NB_SLOPES_CK = 3,
  parameter int unsigned NB_SLOPES_D  = 3,
  parameter int unsigned FRAME        = 1024,
  parameter int unsigned CK_EDGE      = 512,
  parameter int unsigned OFFS_MAX     = 500,
  parameter int unsigned OFFS_STEP    = 1,
  parameter int unsigned SETTLE_CYC   = 2048,
  parameter int unsigned CAPT_DLY     = 16,
  localparam int unsigned CKI_W  = idx_w(NB_SLOPES_CK),
  localparam int unsigned DI_W   = idx_w(NB_SLOPES_D),
  localparam int unsigned OFFS_W = $clog2(OFFS_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              dut_ck,
  output logic              dut_d,
  input  logic              dut_q,
  output logic [CKI_W-1:0]  ck_slope_idx,
  output logic [DI_W-1:0]   d_slope_idx,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CKI_W-1:0]  res_ck_idx,
  output logic [DI_W-1:0]   res_d_idx,
  output logic [OFFS_W-1:0] res_offset,
  output logic [1:0]        res_status
);

  localparam int unsigned FW = $clog2(FRAME);
  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);

  localparam logic [FW-1:0]     F_LAST = FW'(FRAME - 1);
  localparam logic [FW-1:0]     F_CK   = FW'(CK_EDGE);
  localparam logic [FW-1:0]     F_SAMP = FW'(CK_EDGE + CAPT_DLY);
  localparam logic [SW-1:0]     S_END  = SW'(SETTLE_CYC);
  localparam logic [OFFS_W-1:0] O_MAX  = OFFS_W'(OFFS_MAX);
  localparam logic [OFFS_W-1:0] O_STEP = OFFS_W'(OFFS_STEP);
  localparam logic [OFFS_W-1:0] O_NONE = OFFS_ALL_ONES[OFFS_W-1:0];
  localparam logic [CKI_W-1:0]  CK_LAST = CKI_W'(NB_SLOPES_CK - 1);
  localparam logic [DI_W-1:0]   D_LAST  = DI_W'(NB_SLOPES_D - 1);

  state_t              state, state_n;
  status_t             status_r, status_n;
  logic                mode_r, mode_n;
  logic [CKI_W-1:0]    ck_idx, ck_idx_n;
  logic [DI_W-1:0]     d_idx, d_idx_n;
  logic [OFFS_W-1:0]   offset, offset_n;
  logic [OFFS_W-1:0]   last_pass, last_pass_n;
  logic [OFFS_W-1:0]   res_off_r, res_off_n;
  logic                pass_seen, pass_seen_n;
  logic                trial_pass, trial_pass_n;
  logic                clr_ok, clr_ok_n;
  logic [FW-1:0]       fcnt, fcnt_n;
  logic [SW-1:0]       scnt, scnt_n;
  logic                ck_n, d_n, done_n;
  logic                q_s;

  q_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (dut_q),
    .q   (q_s)
  );

  assign busy         = (state != S_IDLE);
  assign res_valid    = (state == S_REPORT);
  assign ck_slope_idx = ck_idx;
  assign d_slope_idx  = d_idx;
  assign res_ck_idx   = ck_idx;
  assign res_d_idx    = d_idx;
  assign res_offset   = res_off_r;
  assign res_status   = status_r;

  always_comb begin
    state_n      = state;
    status_n     = status_r;
    mode_n       = mode_r;
    ck_idx_n     = ck_idx;
    d_idx_n      = d_idx;
    offset_n     = offset;
    last_pass_n  = last_pass;
    res_off_n    = res_off_r;
    pass_seen_n  = pass_seen;
    trial_pass_n = trial_pass;
    clr_ok_n     = clr_ok;
    scnt_n       = scnt;
    done_n       = 1'b0;
    d_n          = 1'b0;
    fcnt_n       = (fcnt == F_LAST) ? '0 : fcnt + FW'(1);
    // dut_ck/dut_d are registered from the current tick, so both lag the
    // frame counter by one clk; their relative timing is exact.
    ck_n         = (state != S_IDLE) && (fcnt >= F_CK);

    unique case (state)
      S_IDLE: begin
        fcnt_n = '0;
        if (start) begin
          mode_n      = mode;
          ck_idx_n    = '0;
          d_idx_n     = '0;
          offset_n    = O_MAX;
          pass_seen_n = 1'b0;
          scnt_n      = '0;
          state_n     = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (scnt != S_END) scnt_n = scnt + SW'(1);
        else if (fcnt == F_LAST) state_n = S_TRIAL;   // trial starts at tick 0
      end

      S_TRIAL: begin
        // offset < CK_EDGE and < FRAME-CK_EDGE, so neither edge wraps
        d_n = mode_r ? (fcnt < F_CK + FW'(offset))
                     : (fcnt >= F_CK - FW'(offset));
        if (fcnt == F_SAMP) trial_pass_n = q_s;
        if (fcnt == F_LAST) state_n = S_CLEAR;
      end

      S_CLEAR: begin
        if (fcnt == F_SAMP) clr_ok_n = ~q_s;
        if (fcnt == F_LAST) begin
          state_n = S_REPORT;
          if (!clr_ok) begin
            status_n  = ST_CLRERR;
            res_off_n = O_NONE;
          end else if (trial_pass) begin
            last_pass_n = offset;
            pass_seen_n = 1'b1;
            if (32'(offset) < OFFS_STEP) begin
              status_n  = ST_ALLPASS;
              res_off_n = offset;
            end else begin
              offset_n = offset - O_STEP;
              state_n  = S_TRIAL;
            end
          end else if (!pass_seen) begin
            status_n  = ST_NEVER;
            res_off_n = O_NONE;
          end else begin
            status_n  = ST_FOUND;
            res_off_n = last_pass;
          end
        end
      end

      S_REPORT: begin
        if (res_ready) begin
          offset_n    = O_MAX;
          pass_seen_n = 1'b0;
          scnt_n      = '0;
          if (ck_idx == CK_LAST && d_idx == D_LAST) begin
            state_n  = S_IDLE;
            done_n   = 1'b1;
            ck_idx_n = '0;
            d_idx_n  = '0;
          end else begin
            state_n = S_SETTLE;
            if (d_idx == D_LAST) begin
              d_idx_n  = '0;
              ck_idx_n = ck_idx + CKI_W'(1);
            end else begin
              d_idx_n = d_idx + DI_W'(1);
            end
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      status_r   <= ST_FOUND;
      mode_r     <= 1'b0;
      ck_idx     <= '0;
      d_idx      <= '0;
      offset     <= '0;
      last_pass  <= '0;
      res_off_r  <= '0;
      pass_seen  <= 1'b0;
      trial_pass <= 1'b0;
      clr_ok     <= 1'b0;
      fcnt       <= '0;
      scnt       <= '0;
      dut_ck     <= 1'b0;
      dut_d      <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      status_r   <= status_n;
      mode_r     <= mode_n;
      ck_idx     <= ck_idx_n;
      d_idx      <= d_idx_n;
      offset     <= offset_n;
      last_pass  <= last_pass_n;
      res_off_r  <= res_off_n;
      pass_seen  <= pass_seen_n;
      trial_pass <= trial_pass_n;
      clr_ok     <= clr_ok_n;
      fcnt       <= fcnt_n;
      scnt       <= scnt_n;
      dut_ck     <= ck_n;
      dut_d      <= d_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_setup_hold_sweep_ctrl.sv
// Directed bench for setup_hold_sweep_ctrl with a shrunk frame so full
// sweeps stay short. A behavioural flop with programmable setup/hold
// requirements (or stuck outputs) answers the sequencer.
module tb_setup_hold_sweep_ctrl;

  localparam int NB_CK = 3, NB_D = 3, FRAME = 64, CK_EDGE = 32;
  localparam int OFFS_MAX = 20, OFFS_STEP = 4, SETTLE = 16, CAPT = 20;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic       res_ready = 1'b1, dut_q = 1'b0;
  logic       busy, done, dut_ck, dut_d, res_valid;
  logic [1:0] ck_slope_idx, d_slope_idx, res_ck_idx, res_d_idx, res_status;
  logic [4:0] res_offset;

  setup_hold_sweep_ctrl #(
    .NB_SLOPES_CK(NB_CK), .NB_SLOPES_D(NB_D), .FRAME(FRAME), .CK_EDGE(CK_EDGE),
    .OFFS_MAX(OFFS_MAX), .OFFS_STEP(OFFS_STEP), .SETTLE_CYC(SETTLE), .CAPT_DLY(CAPT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
    .dut_ck(dut_ck), .dut_d(dut_d), .dut_q(dut_q),
    .ck_slope_idx(ck_slope_idx), .d_slope_idx(d_slope_idx),
    .res_valid(res_valid), .res_ready(res_ready), .res_ck_idx(res_ck_idx),
    .res_d_idx(res_d_idx), .res_offset(res_offset), .res_status(res_status)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  // ---------------- behavioural DUT flop ----------------
  int s_req = 0, h_req = 0, q_force = 0;    // q_force: 0 model, 1 stuck0, 2 stuck1
  int tick = 0, d_hi = 0, h_cnt = 0, ck_rise_tick = 0, d_rise_tick = 0;
  logic ck_prev = 1'b0, d_prev = 1'b0;
  int rise_gaps[$], fall_gaps[$];

  always @(posedge clk) begin
    logic qn;
    qn = dut_q;
    tick++;
    if (dut_d && !d_prev) d_rise_tick = tick;
    if (dut_ck && !ck_prev) begin
      ck_rise_tick = tick;
      if (dut_d) rise_gaps.push_back(tick - d_rise_tick);
      qn = dut_d && (d_hi >= s_req);
      h_cnt = dut_d ? 1 : 0;
    end else if (h_cnt > 0 && h_cnt < h_req) begin
      if (dut_d) h_cnt++;
      else begin
        qn = 1'b0;
        h_cnt = 0;
      end
    end
    if (!dut_d && d_prev) fall_gaps.push_back(tick - ck_rise_tick);
    d_hi = dut_d ? d_hi + 1 : 0;
    if (q_force == 1) qn = 1'b0;
    if (q_force == 2) qn = 1'b1;
    dut_q <= qn;
    ck_prev = dut_ck;
    d_prev = dut_d;
  end

  // ---------------- sweep driver / collector ----------------
  typedef struct { int ck; int d; int off; int st; } res_t;
  res_t res_q[$];
  bit got_done, busy_after_start;

  task automatic do_sweep(input logic m);
    res_t r;
    res_q.delete();
    rise_gaps.delete();
    fall_gaps.delete();
    got_done = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    mode = m;
    @(negedge clk);
    start = 1'b0;
    busy_after_start = busy;
    for (int c = 0; c < 20000 && !got_done; c++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
      else if (res_valid) begin
        r.ck = int'(res_ck_idx); r.d = int'(res_d_idx);
        r.off = int'(res_offset); r.st = int'(res_status);
        res_q.push_back(r);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [19:0] outs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    outs = {busy, done, dut_ck, dut_d, ck_slope_idx, d_slope_idx, res_valid,
            res_ck_idx, res_d_idx, res_offset, res_status};
    n_checks++;
    if (outs !== 20'd0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", outs); end
    rst = 1'b0;
    res_ready = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({busy, res_valid, done} !== 3'b000) begin
      n_fail++; $display("FAIL idle_ready_no_effect got %b want 000", {busy, res_valid, done});
    end
  endtask

  task automatic test_setup_boundary;
    int exp_g[5] = '{20, 16, 12, 8, 4};
    s_req = 6; h_req = 0; q_force = 0;
    do_sweep(1'b0);
    n_checks++;
    if (busy_after_start !== 1'b1) begin n_fail++; $display("FAIL setup_busy got %b want 1", busy_after_start); end
    n_checks++;
    if (!got_done) begin n_fail++; $display("FAIL setup_done got timeout want done"); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL setup_busy_at_done got %b want 0", busy); end
    n_checks++;
    if (res_q.size() != 9) begin n_fail++; $display("FAIL setup_count got %0d want 9", res_q.size()); end
    foreach (res_q[k]) begin
      n_checks++;
      if (res_q[k].ck != k / 3 || res_q[k].d != k % 3 || res_q[k].off != 8 || res_q[k].st != 0) begin
        n_fail++;
        $display("FAIL setup_res%0d got ck=%0d d=%0d off=%0d st=%0d want ck=%0d d=%0d off=8 st=0",
                 k, res_q[k].ck, res_q[k].d, res_q[k].off, res_q[k].st, k / 3, k % 3);
      end
    end
    n_checks++;
    if (rise_gaps.size() != 45) begin n_fail++; $display("FAIL setup_trials got %0d want 45", rise_gaps.size()); end
    for (int i = 0; i < 5 && i < rise_gaps.size(); i++) begin
      n_checks++;
      if (rise_gaps[i] != exp_g[i]) begin
        n_fail++; $display("FAIL setup_d_rise%0d got %0d want %0d", i, rise_gaps[i], exp_g[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width got %b want 0", done); end
  endtask

  task automatic test_setup_allpass;
    s_req = 0; h_req = 0; q_force = 0;
    do_sweep(1'b0);
    n_checks++;
    if (!got_done || res_q.size() != 9) begin
      n_fail++; $display("FAIL allpass_count got %0d done=%0d want 9", res_q.size(), got_done);
    end
    foreach (res_q[k]) begin
      n_checks++;
      if (res_q[k].off != 0 || res_q[k].st != 1) begin
        n_fail++; $display("FAIL allpass_res%0d got off=%0d st=%0d want off=0 st=1", k, res_q[k].off, res_q[k].st);
      end
    end
    n_checks++;
    if (rise_gaps.size() != 54 || rise_gaps[5] != 0) begin
      n_fail++; $display("FAIL allpass_trials got n=%0d last=%0d want n=54 last=0",
                         rise_gaps.size(), rise_gaps.size() > 5 ? rise_gaps[5] : -1);
    end
  endtask

  task automatic test_stuck;
    q_force = 1;
    do_sweep(1'b0);
    n_checks++;
    if (res_q.size() != 9 || rise_gaps.size() != 9) begin
      n_fail++; $display("FAIL stuck0_count got res=%0d trials=%0d want 9/9", res_q.size(), rise_gaps.size());
    end
    foreach (res_q[k]) begin
      n_checks++;
      if (res_q[k].off != 31 || res_q[k].st != 2) begin
        n_fail++; $display("FAIL stuck0_res%0d got off=%0d st=%0d want off=31 st=2", k, res_q[k].off, res_q[k].st);
      end
    end
    q_force = 2;
    do_sweep(1'b0);
    n_checks++;
    if (res_q.size() != 9 || rise_gaps.size() != 9) begin
      n_fail++; $display("FAIL stuck1_count got res=%0d trials=%0d want 9/9", res_q.size(), rise_gaps.size());
    end
    foreach (res_q[k]) begin
      n_checks++;
      if (res_q[k].st != 3) begin
        n_fail++; $display("FAIL stuck1_res%0d got st=%0d want 3", k, res_q[k].st);
      end
    end
    q_force = 0;
  endtask

  task automatic test_hold;
    int exp_g[4] = '{20, 16, 12, 8};
    s_req = 0; h_req = 12; q_force = 0;
    do_sweep(1'b1);
    n_checks++;
    if (!got_done || res_q.size() != 9) begin
      n_fail++; $display("FAIL hold_count got %0d done=%0d want 9", res_q.size(), got_done);
    end
    foreach (res_q[k]) begin
      n_checks++;
      if (res_q[k].off != 12 || res_q[k].st != 0) begin
        n_fail++; $display("FAIL hold_res%0d got off=%0d st=%0d want off=12 st=0", k, res_q[k].off, res_q[k].st);
      end
    end
    n_checks++;
    if (fall_gaps.size() != 36) begin n_fail++; $display("FAIL hold_trials got %0d want 36", fall_gaps.size()); end
    for (int i = 0; i < 4 && i < fall_gaps.size(); i++) begin
      n_checks++;
      if (fall_gaps[i] != exp_g[i]) begin
        n_fail++; $display("FAIL hold_d_fall%0d got %0d want %0d", i, fall_gaps[i], exp_g[i]);
      end
    end
    h_req = 0;
  endtask

  task automatic test_backpressure;
    logic [10:0] snap;
    bit seen, moved;
    q_force = 1;
    res_ready = 1'b0;
    @(negedge clk); start = 1'b1; mode = 1'b0;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL bp_valid got timeout want res_valid"); end
    snap = {res_ck_idx, res_d_idx, res_offset, res_status};
    n_checks++;
    if (snap !== {2'd0, 2'd0, 5'd31, 2'd2}) begin n_fail++; $display("FAIL bp_payload got %h want %h", snap, {2'd0, 2'd0, 5'd31, 2'd2}); end
    moved = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (!res_valid || {res_ck_idx, res_d_idx, res_offset, res_status} !== snap ||
          d_slope_idx !== 2'd0 || ck_slope_idx !== 2'd0) moved = 1'b1;
    end
    n_checks++;
    if (moved) begin n_fail++; $display("FAIL bp_stable got change want stable"); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++;
    if ({res_valid, d_slope_idx, ck_slope_idx} !== 5'b0_01_00) begin
      n_fail++; $display("FAIL bp_advance got %b want 00100", {res_valid, d_slope_idx, ck_slope_idx});
    end
    res_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL bp_finish got timeout want done"); end
    q_force = 0;
  endtask

  task automatic test_reset_mid;
    logic [19:0] outs;
    bit seen;
    s_req = 6; q_force = 0;
    @(negedge clk); start = 1'b1; mode = 1'b0;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (dut_d) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rst_mid_trial got timeout want dut_d"); end
    rst = 1'b1;
    #1;
    outs = {busy, done, dut_ck, dut_d, ck_slope_idx, d_slope_idx, res_valid,
            res_ck_idx, res_d_idx, res_offset, res_status};
    n_checks++;
    if (outs !== 20'd0) begin n_fail++; $display("FAIL rst_mid_outputs got %h want 0", outs); end
    @(negedge clk);
    rst = 1'b0;
    do_sweep(1'b0);
    n_checks++;
    if (!got_done || res_q.size() != 9) begin
      n_fail++; $display("FAIL rst_resweep_count got %0d want 9", res_q.size());
    end
    foreach (res_q[k]) begin
      n_checks++;
      if (res_q[k].ck != k / 3 || res_q[k].d != k % 3 || res_q[k].off != 8 || res_q[k].st != 0) begin
        n_fail++; $display("FAIL rst_resweep_res%0d got off=%0d st=%0d want off=8 st=0", k, res_q[k].off, res_q[k].st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_setup_boundary();
    test_setup_allpass();
    test_stuck();
    test_hold();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
